filt_ppd_mac: RTL
=================

Name: filt_ppd_mac

Overview:
Polyphase decimation FIR filter, the receive-side counterpart of the polyphase interpolator: it consumes input-rate samples and emits one filtered sample per gp_decimation_factor accepted inputs. It runs on a single input-rate clock with a valid strobe, so no derived slow/fast clocks are generated. Each accepted sample is multiplied by its own phase bank of L/M coefficients and accumulated; the accumulator dumps to a registered output once per decimated period. It sits after upstream modulators/CIC stages and feeds lower-rate DSP.

Parameters:
gp_idata_width, 16, signed input sample width
gp_decimation_factor, 4, decimation ratio M (>=2)
gp_coeff_length, 16, tap count L; must be an integer multiple of M
gp_coeff_width, 16, signed coefficient width
gp_coeffs, all taps = 1, packed signed coefficients, h[i] = gp_coeffs[i*gp_coeff_width +: gp_coeff_width]
gp_comm_phase, 0, phase counter value loaded at reset/clear (0..M-1)
gp_odata_width, gp_idata_width+gp_coeff_width+clog2(gp_coeff_length), full-precision output width

Ports:
i_clk  in  1  input-rate clock, rising edge
i_rst_an  in  1  asynchronous active-low reset
i_ena  in  1  global enable; 0 stalls the entire block
i_clr  in  1  synchronous clear (same effect as reset, taken when i_ena=1)
i_valid  in  1  input sample strobe
i_data  in  gp_idata_width  signed input sample
o_data  out  gp_odata_width  signed decimated output, registered
o_valid  out  1  one-cycle strobe marking a new o_data

Behaviour:
- Reset (i_rst_an=0, asynchronous): o_data=0, o_valid=0, history=0, accumulator=0, pipeline cleared, phase counter=gp_comm_phase.
- Sample accepted on a rising edge iff i_ena=1 and i_valid=1 and i_clr=0.
- Phase counter p: increments on each accepted sample and wraps M-1 -> 0.
- An accepted sample arriving while p=M-1 is an output sample n. Its output value is y = sum_{i=0..L-1} h[i]*x[n-i], where x[n] is that sample and x[n-i] is the i-th previously accepted sample.
- Samples not accepted since reset/clear count as 0.
- Result must be bit-exact to this direct-form sum. The internal polyphase partitioning is free.
- Arithmetic: signed, full precision, no rounding and no saturation. gp_odata_width is sufficient for the worst case (all operands at the negative extreme).
- Latency: if acceptance edge E carries an output sample, o_data updates and o_valid=1 on edge E+2 (only edges with i_ena=1 count). o_valid is 1 for exactly one enabled cycle and is 0 otherwise.
- o_data holds its last value between strobes.
- i_ena=0: all state frozen (history, p, accumulator, pipeline). o_valid is forced to 0 during the stall, and a strobe pending in the pipeline is delivered after i_ena returns. o_data holds.
- i_valid=0 with i_ena=1: pipeline continues to drain; history and p hold.
- i_clr=1 with i_ena=1: the same clear as reset, applied on that edge. It discards the concurrent i_valid sample and any in-flight output. The next cycle has o_valid=0 and o_data=0.
- Back-to-back i_valid every cycle is sustained with no input stall. There is no back-pressure.
- Reset asserted mid-operation immediately clears all outputs. The first output after release comes on the (M - gp_comm_phase)-th accepted sample.
- Consecutive output samples are separated by exactly M accepted samples.

Test Plan:
- Impulse: M=4, L=16, h[i]=i+1, x[0]=1000 then zeros, i_valid every cycle -> o_valid pulses after accepted samples 3,7,11,15,19 with o_data 4000, 8000, 12000, 16000, 0. Each pulse arrives 2 edges after acceptance.
- DC: all h=1, x=100 constant -> o_data 400, 800, 1200, 1600, then 1600 steady.
- Extremes: h all -32768, x all -32768, L=16 -> steady o_data = 2^34 (0x4_0000_0000, 36-bit), no overflow. With x all +32767 -> -16*32767*32768.
- Phase offset: gp_comm_phase=2, impulse test stimulus -> first strobe after accepted sample 1 with o_data 2000, next after sample 5 with 6000.
- Stall/gaps: impulse test with i_ena low 3 cycles immediately after the phase-3 sample, plus random i_valid gaps -> same o_data sequence, o_valid never high while i_ena=0, strobe delayed by exactly the stalled cycles.
- Clear/reset mid-stream: DC test, i_clr pulse after 6 accepted samples -> no strobe for the in-flight sample, outputs restart at 400 after 4 more accepted samples. Async i_rst_an pulse between edges -> o_data/o_valid go to 0 immediately.

Source files
------------

// File: rtl/filt_ppd_mac.sv
// Polyphase decimation FIR filter (decimate by M, L taps).
// Each accepted sample is multiplied by its phase bank of L/M coefficients and
// summed into L/M partial accumulators. Partial q holds the part of the output
// that lies q decimated periods ahead. When a period closes, partial 0 is dumped
// to the output and the partials shift down by one period.
// Pipeline: products registered at acceptance edge E, accumulate/dump at E+1,
// output register at E+2.
module filt_ppd_mac #(
    parameter int gp_idata_width       = 16,
    parameter int gp_decimation_factor = 4,
    parameter int gp_coeff_length      = 16,
    parameter int gp_coeff_width       = 16,
    parameter logic [gp_coeff_length*gp_coeff_width-1:0] gp_coeffs =
        {gp_coeff_length{{{(gp_coeff_width-1){1'b0}}, 1'b1}}},
    parameter int gp_comm_phase        = 0,
    parameter int gp_odata_width       = gp_idata_width + gp_coeff_width + $clog2(gp_coeff_length)
) (
    input  logic                              i_clk,
    input  logic                              i_rst_an,
    input  logic                              i_ena,
    input  logic                              i_clr,
    input  logic                              i_valid,
    input  logic signed [gp_idata_width-1:0]  i_data,
    output logic signed [gp_odata_width-1:0]  o_data,
    output logic                              o_valid
);

    localparam int M    = gp_decimation_factor;
    localparam int L    = gp_coeff_length;
    localparam int K    = L / M;
    localparam int CW   = gp_coeff_width;
    localparam int PW   = gp_idata_width + gp_coeff_width;
    localparam int OW   = gp_odata_width;
    localparam int PH_W = $clog2(M);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(M - 1);
    localparam logic [PH_W-1:0] PH_INIT = PH_W'(gp_comm_phase);

    // Phase counter and the decode of "this sample closes a decimated period".
    logic [PH_W-1:0]         r_phase;
    logic                    w_last;

    // Coefficient bank selected by the current phase.
    logic signed [CW-1:0]    w_coef [K];

    // Stage A: products of the accepted sample with its bank.
    logic                    r_a_vld;
    logic                    r_a_last;
    logic signed [PW-1:0]    r_a_prod [K];

    // Stage B: partial sums and the dumped filter result.
    logic signed [OW-1:0]    r_acc [K];
    logic signed [OW-1:0]    r_y;
    logic                    r_y_vld;

    // Stage C: output register.
    logic signed [OW-1:0]    r_odata;
    logic                    r_ovalid;

    assign w_last = (r_phase == PH_LAST);

    // Select h[k + q*M] for every partial q, where k = M-1-phase is the distance
    // from this sample to the end of its decimated period.
    always_comb begin
        for (int q = 0; q < K; q++) begin
            // NOTE: every combinational output gets a default before any
            // conditional assignment, otherwise a latch is inferred.
            w_coef[q] = '0;
            for (int k = 0; k < M; k++) begin
                if (r_phase == PH_W'(M - 1 - k)) begin
                    w_coef[q] = gp_coeffs[(k + q*M)*CW +: CW];
                end
            end
        end
    end

    // Stage A: accept a sample, advance the phase and register its products.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            r_phase  <= PH_INIT;
            r_a_vld  <= 1'b0;
            r_a_last <= 1'b0;
            // NOTE: the product and partial-sum arrays are datapath state that
            // must start from zero (unseen samples count as 0), so they are reset
            // like any control register rather than left as uninitialised storage.
            for (int q = 0; q < K; q++) begin
                r_a_prod[q] <= '0;
            end
        end else if (i_ena) begin
            if (i_clr) begin
                r_phase  <= PH_INIT;
                r_a_vld  <= 1'b0;
                r_a_last <= 1'b0;
                for (int q = 0; q < K; q++) begin
                    r_a_prod[q] <= '0;
                end
            end else begin
                // NOTE: non-blocking assignments keep every stage reading the
                // pre-edge value of the previous stage, which is what a register
                // pipeline means.
                r_a_vld  <= i_valid;
                r_a_last <= i_valid & w_last;
                if (i_valid) begin
                    r_phase <= w_last ? '0 : r_phase + PH_W'(1);
                    for (int q = 0; q < K; q++) begin
                        r_a_prod[q] <= PW'(i_data) * PW'(w_coef[q]);
                    end
                end
            end
        end
    end

    // Stage B: add products into the partials; on a period end dump partial 0
    // and shift the remaining partials one period closer.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            r_y     <= '0;
            r_y_vld <= 1'b0;
            for (int q = 0; q < K; q++) begin
                r_acc[q] <= '0;
            end
        end else if (i_ena) begin
            if (i_clr) begin
                r_y     <= '0;
                r_y_vld <= 1'b0;
                for (int q = 0; q < K; q++) begin
                    r_acc[q] <= '0;
                end
            end else begin
                r_y_vld <= r_a_vld & r_a_last;
                if (r_a_vld) begin
                    if (r_a_last) begin
                        r_y <= r_acc[0] + OW'(r_a_prod[0]);
                        for (int q = 0; q < K - 1; q++) begin
                            r_acc[q] <= r_acc[q+1] + OW'(r_a_prod[q+1]);
                        end
                        r_acc[K-1] <= '0;
                    end else begin
                        for (int q = 0; q < K; q++) begin
                            r_acc[q] <= r_acc[q] + OW'(r_a_prod[q]);
                        end
                    end
                end
            end
        end
    end

    // Stage C: output register; data holds between strobes.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            r_odata  <= '0;
            r_ovalid <= 1'b0;
        end else if (i_ena) begin
            if (i_clr) begin
                r_odata  <= '0;
                r_ovalid <= 1'b0;
            end else begin
                r_ovalid <= r_y_vld;
                if (r_y_vld) begin
                    r_odata <= r_y;
                end
            end
        end
    end

    // A strobe caught by a stall stays pending in r_ovalid and is shown once
    // the block is enabled again.
    assign o_data  = r_odata;
    assign o_valid = r_ovalid & i_ena;

endmodule
